// File: rtl/pwm_tick_gen_if.sv
// pwm_tick_gen_if -- configuration handshake for pwm_tick_gen.
//   cfg_valid  : configuration offer (master -> slave)
//   cfg_ready  : pending slot empty   (slave -> master)
//   cfg_period : period value P, one period is P+1 ticks (edge-aligned)
//   cfg_duty   : duty value D, output high for D ticks per period
// A configuration transfers on a cycle where cfg_valid and cfg_ready are both high.
interface pwm_tick_gen_if #(
  parameter int unsigned NBITS = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [NBITS-1:0] cfg_period;
  logic [NBITS-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen -- tick-driven PWM generator with double-buffered configuration.
// Ports:
//   clk        : system clock, all flops on rising edge
//   rstn       : synchronous active-low reset
//   tick       : one-cycle count enable from the upstream divider
//   en         : level-sensitive run request
//   cfg        : pwm_tick_gen_if.slave (cfg_valid/cfg_ready/cfg_period/cfg_duty)
//   pwm_out    : registered PWM output
//   period_end : one-cycle pulse after each period wrap
//   busy       : high while the FSM is not IDLE
// Build option: define PWM_CENTER_ALIGN_EN for up/down (center-aligned)
// counting with a 2P-tick period; default is edge-aligned up-counting.
module pwm_tick_gen #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic             en,
  pwm_tick_gen_if.slave    cfg,
  output logic             pwm_out,
  output logic             period_end,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_cnt;
  logic [NBITS-1:0] r_period_a;
  logic [NBITS-1:0] r_duty_a;
  logic [NBITS-1:0] r_pend_period;
  logic [NBITS-1:0] r_pend_duty;
  logic             r_pend_valid;
  logic             r_pwm;
  logic             r_period_end;

  logic             w_accept;
  logic             w_wrap;
  logic [NBITS-1:0] w_cnt_nxt;

`ifdef PWM_CENTER_ALIGN_EN
  logic             r_dir;      // 1 while counting down
  logic             w_dir_nxt;
`endif

  assign w_accept      = cfg.cfg_valid && !r_pend_valid;
  assign cfg.cfg_ready = !r_pend_valid;
  assign busy          = (r_state != S_IDLE);
  assign pwm_out       = r_pwm;
  assign period_end    = r_period_end;

  // Next count and wrap detection, applied only on tick in RUN/DRAIN.
  always_comb begin
    w_wrap    = 1'b0;
    w_cnt_nxt = r_cnt;
`ifdef PWM_CENTER_ALIGN_EN
    w_dir_nxt = r_dir;
    if (!r_dir) begin
      if (r_cnt == r_period_a) begin
        // P=0 or P=1 has no down leg: the top of the count is the wrap.
        if (r_period_a <= NBITS'(1)) begin
          w_wrap    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_dir_nxt = 1'b1;
          w_cnt_nxt = r_cnt - NBITS'(1);
        end
      end else begin
        w_cnt_nxt = r_cnt + NBITS'(1);
      end
    end else begin
      if (r_cnt == NBITS'(1)) begin
        w_wrap    = 1'b1;
        w_dir_nxt = 1'b0;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt - NBITS'(1);
      end
    end
`else
    if (r_cnt == r_period_a) begin
      w_wrap    = 1'b1;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + NBITS'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_period_a    <= '0;
      r_duty_a      <= '0;
      r_pend_period <= '0;
      r_pend_duty   <= '0;
      r_pend_valid  <= 1'b0;
      r_pwm         <= 1'b0;
      r_period_end  <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      r_dir         <= 1'b0;
`endif
    end else begin
      r_period_end <= 1'b0;
      r_pwm        <= (r_state != S_IDLE) && (r_cnt < r_duty_a);

      // Accept only into an empty slot, so it never collides with a consume.
      if (w_accept) begin
        r_pend_period <= cfg.cfg_period;
        r_pend_duty   <= cfg.cfg_duty;
        r_pend_valid  <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
`ifdef PWM_CENTER_ALIGN_EN
          r_dir <= 1'b0;
`endif
          if (r_pend_valid) begin
            r_period_a   <= r_pend_period;
            r_duty_a     <= r_pend_duty;
            r_pend_valid <= 1'b0;
          end
          if (en) begin
            r_state <= S_RUN;
          end
        end

        S_RUN, S_DRAIN: begin
          if (r_state == S_RUN) begin
            if (!en) r_state <= S_DRAIN;
          end else if (en) begin
            r_state <= S_RUN;
          end

          if (tick) begin
            r_cnt <= w_cnt_nxt;
`ifdef PWM_CENTER_ALIGN_EN
            r_dir <= w_dir_nxt;
`endif
            if (w_wrap) begin
              r_period_end <= 1'b1;
              if (r_pend_valid) begin
                r_period_a   <= r_pend_period;
                r_duty_a     <= r_pend_duty;
                r_pend_valid <= 1'b0;
              end
              if (r_state == S_DRAIN && !en) begin
                r_state <= S_IDLE;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_tick_gen.sv
// tb_pwm_tick_gen -- directed self-checking bench for pwm_tick_gen (NBITS=8).
module tb_pwm_tick_gen;

  localparam int unsigned NBITS = 8;

  logic clk;
  logic rstn;
  logic tick;
  logic en;
  logic pwm_out;
  logic period_end;
  logic busy;

  int n_checks;
  int n_errors;

  pwm_tick_gen_if #(.NBITS(NBITS)) cfg_if ();

  pwm_tick_gen #(.NBITS(NBITS)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .en         (en),
    .cfg        (cfg_if),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a config while running, then wait for the wrap that applies it.
  task automatic load_cfg(input logic [NBITS-1:0] p, input logic [NBITS-1:0] d);
    bit seen;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = p;
    cfg_if.cfg_duty   = d;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("ready_after_accept", int'(cfg_if.cfg_ready), 0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (period_end) begin
        seen = 1'b1;
        chk("ready_at_wrap", int'(cfg_if.cfg_ready), 1);
      end else begin
        chk("ready_before_wrap", int'(cfg_if.cfg_ready), 0);
      end
    end
    if (!seen) chk("wrap_wait_timeout", 0, 1);
  endtask

  // Check n cycles of a 4-tick edge-aligned pattern; pat[k] is the k-th pwm value.
  task automatic run_pattern(input string tag, input logic [3:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_pwm"}, int'(pwm_out), int'(pat[k % 4]));
      chk({tag, "_pe"}, int'(period_end), (k % 4 == 3) ? 1 : 0);
    end
  endtask

  initial begin
    logic [11:0] st_pwm;
    logic [11:0] st_pe;
    logic [5:0]  ca_pwm;

    n_checks = 0;
    n_errors = 0;

    // Reset with random inputs
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick              = 1'($urandom);
      en                = 1'($urandom);
      cfg_if.cfg_valid  = 1'($urandom);
      cfg_if.cfg_period = NBITS'($urandom);
      cfg_if.cfg_duty   = NBITS'($urandom);
      step();
    end
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_pe", int'(period_end), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_if.cfg_ready), 1);

    rstn = 1'b1;
    tick = 1'b0;
    en   = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(cfg_if.cfg_ready), 1);

    // Load P=3 D=2 from IDLE and start
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 8'd3;
    cfg_if.cfg_duty   = 8'd2;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("idle_pend_ready", int'(cfg_if.cfg_ready), 0);
    chk("idle_pend_busy", int'(busy), 0);

`ifdef PWM_CENTER_ALIGN_EN
    en   = 1'b1;
    tick = 1'b1;
    step();
    chk("ca_start_busy", int'(busy), 1);
    chk("ca_start_pwm", int'(pwm_out), 0);
    // cnt 0,1,2,3,2,1 -> pwm 1,1,0,0,0,1, wrap on 1->0
    ca_pwm = 6'b100011;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("ca_pwm", int'(pwm_out), int'(ca_pwm[k % 6]));
      chk("ca_pe", int'(period_end), (k % 6 == 5) ? 1 : 0);
    end
`else
    en   = 1'b1;
    tick = 1'b1;
    step();
    chk("start_busy", int'(busy), 1);
    chk("start_ready", int'(cfg_if.cfg_ready), 1);
    chk("start_pwm", int'(pwm_out), 0);
    run_pattern("p3d2", 4'b0011, 12);
    chk("run_busy", int'(busy), 1);

    // Mid-period update to D=1, takes effect after the wrap
    load_cfg(8'd3, 8'd1);
    run_pattern("p3d1", 4'b0001, 8);

    // D=0 keeps output low
    load_cfg(8'd3, 8'd0);
    run_pattern("d0", 4'b0000, 8);

    // D>P keeps output high
    load_cfg(8'd3, 8'd4);
    run_pattern("dgtp", 4'b1111, 8);

    // Tick every 3rd clock with P=3 D=2
    load_cfg(8'd3, 8'd2);
    st_pwm = 12'b1100_0000_1111; // bit i-1 for iteration i
    st_pe  = 12'b0010_0000_0000;
    for (int i = 1; i <= 12; i++) begin
      tick = (i % 3 == 1);
      step();
      chk("slow_pwm", int'(pwm_out), int'(st_pwm[i-1]));
      chk("slow_pe", int'(period_end), int'(st_pe[i-1]));
    end

    // Drop en at cnt=1: period completes then IDLE
    tick = 1'b1;
    step();
    en = 1'b0;
    step();
    chk("drain_busy", int'(busy), 1);
    chk("drain_pwm", int'(pwm_out), 1);
    step();
    chk("drain_busy2", int'(busy), 1);
    step();
    chk("drain_pe", int'(period_end), 1);
    chk("drain_busy_fall", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_drain_pwm", int'(pwm_out), 0);
      chk("post_drain_pe", int'(period_end), 0);
      chk("post_drain_busy", int'(busy), 0);
    end

    // P=0: period_end on every tick
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 8'd0;
    cfg_if.cfg_duty   = 8'd1;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("p0_pe", int'(period_end), 1);
      chk("p0_pwm", int'(pwm_out), 1);
    end

    // Reset while a pending config is waiting: it must be discarded
    tick = 1'b0;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 8'd3;
    cfg_if.cfg_duty   = 8'd2;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("pend_ready", int'(cfg_if.cfg_ready), 0);
    chk("notick_pe", int'(period_end), 0);
    rstn = 1'b0;
    step();
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_ready", int'(cfg_if.cfg_ready), 1);
    chk("rst2_pwm", int'(pwm_out), 0);
    rstn = 1'b1;
    tick = 1'b1;
    step();
    step();
    chk("rst2_p0_pe", int'(period_end), 1);
    chk("rst2_d0_pwm", int'(pwm_out), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_tick_gen.md
PWM_TICK_GEN -- requirements
Module: pwm_tick_gen

Interface
REQ-001 Parameter: NBITS, 8, width of the counter, period and duty fields.
REQ-002 Port: clk  in  1  system clock; every flop updates on its rising edge.
REQ-003 Port: rstn  in  1  reset, synchronous, active-low.
REQ-004 Port: tick  in  1  one-cycle count enable from the upstream clock-divider stage; the counter advances only on cycles where it is high.
REQ-005 Port: en  in  1  run request, level-sensitive.
REQ-006 Port: cfg_valid  in  1  configuration offer.
REQ-007 Port: cfg_ready  out  1  pending slot empty; a config is accepted when cfg_valid and cfg_ready are both high.
REQ-008 Port: cfg_period  in  NBITS  period value P; one PWM period is P+1 ticks.
REQ-009 Port: cfg_duty  in  NBITS  duty value D; pwm_out is high for D ticks per period.
REQ-010 Port: pwm_out  out  1  registered PWM output.
REQ-011 Port: period_end  out  1  one-cycle pulse at each period wrap.
REQ-012 Port: busy  out  1  high when state is not IDLE.

Function
REQ-013 Internal registers: cnt[NBITS]; active period_a/duty_a; pending pend_period/pend_duty; pend_valid flag.
REQ-014 cfg_ready SHALL equal !pend_valid (combinational); on acceptance, pending registers and pend_valid=1 load the next cycle.
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-016 IDLE: cnt held at 0 and pwm_out=0; if pend_valid=1, pending is copied to active and pend_valid clears, with no tick required.
REQ-017 IDLE -> RUN when en=1; cnt starts at 0.
REQ-018 RUN/DRAIN, on tick: if cnt==period_a then cnt<=0 and period_end<=1 (next cycle), else cnt<=cnt+1.
REQ-019 At a wrap with pend_valid=1, pending SHALL be copied to active in the same edge and pend_valid cleared; a config accepted in the wrap cycle itself SHALL apply at the following wrap (no bypass).
REQ-020 RUN -> DRAIN when en=0; DRAIN -> RUN when en=1 without disturbing cnt; DRAIN -> IDLE at the wrap, with cnt<=0.
REQ-021 pwm_out SHALL be registered as (state!=IDLE) && (cnt < duty_a), giving one clk of latency from cnt.
REQ-022 Boundary cases: D=0 keeps pwm_out always low; D>P keeps pwm_out always high; P=0 gives period_end on every tick.
REQ-023 Without tick, all state, cnt and pwm_out SHALL hold; period_end SHALL be 0.
REQ-024 Unsigned arithmetic only; cnt never exceeds period_a, so no overflow is possible.

Reset
REQ-025 While rstn=0 at a clk edge: state=IDLE; cnt, period_a, duty_a, pend_* and pend_valid=0; pwm_out=0, period_end=0, busy=0; cfg_ready=1.
REQ-026 Reset mid-period SHALL abort immediately; accepted but unapplied configs are discarded.

Configuration
REQ-027 Macro PWM_CENTER_ALIGN_EN defined: cnt counts up 0..P, then down P-1..1, then repeats; the period is 2P ticks (P=0 holds cnt at 0 with period_end on every tick).
REQ-028 In center-aligned mode, the wrap (period_end, pending load, DRAIN exit) SHALL occur at the transition back to 0; the pwm_out rule is unchanged.
REQ-029 Macro undefined: edge-aligned up-count per REQ-018, and no direction register SHALL exist.

Verification (NBITS=8)
REQ-030 rstn=0 for 2 clk, random inputs -> pwm_out=0, period_end=0, busy=0, cfg_ready=1.
REQ-031 cfg P=3 D=2, tick every clk, en=1 -> pwm_out repeats 1,1,0,0; period_end every 4th clk; busy=1.
REQ-032 While running P=3 D=2, offer D=1 mid-period -> cfg_ready=0 until the wrap; pattern becomes 1,0,0,0 from the next period.
REQ-033 D=0 -> pwm_out constantly 0; P=3 D=4 -> pwm_out constantly 1; tick every 3rd clk -> pattern stretched ×3.
REQ-034 en dropped at cnt=1 -> period completes, period_end pulses, busy falls the same cycle, pwm_out=0 thereafter.
REQ-035 PWM_CENTER_ALIGN_EN, P=3 D=2 -> cnt 0,1,2,3,2,1 and pwm_out 1,1,0,0,0,1 repeating; period_end every 6 ticks.
